alu_result_buffer: RTL and testbench



---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_result_if.sv | 18 +
 rtl/alu_result_buffer.sv | 108 ++++++++++
 tb/tb_alu_result_buffer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Holds the default operand width, the result width (operand width plus
// carry), the result type and the opcode encoding used by the ALU, its
// result buffer and the verification IP.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 8;
    localparam int RES_WIDTH      = ALU_DATA_WIDTH + 1;

    typedef logic [RES_WIDTH-1:0] alu_result_t;

    typedef enum logic [1:0] {
        SEL_ADD = 2'd0,
        SEL_SUB = 2'd1,
        SEL_AND = 2'd2,
        SEL_OR  = 2'd3
    } alu_sel_e;

endpackage

// File: rtl/alu_result_if.sv
// Consumer-side handshake bundle of alu_result_buffer, used by the
// result monitor.
//   valid : head entry available
//   ready : consumer accepts head entry
//   data  : head entry (zero while valid is low)
interface alu_result_if
    import alu_pkg::*;
#(
    parameter int W = RES_WIDTH
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport source  (output valid, output data, input  ready);
    modport sink    (input  valid, input  data, output ready);
    modport monitor (input  valid, input  data, input  ready);
endinterface

// File: rtl/alu_result_buffer.sv
// ALU result buffer.
// Absorbs every result strobed by the ALU (which has no backpressure) into
// a small first-word-fall-through FIFO and re-issues results to the
// consumer over valid/ready. A result arriving while the FIFO is full and
// not being drained is dropped and flagged on the sticky overflow_o.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   valid_i, data_i     : result strobe and result from the ALU
//   valid_o, data_o     : head entry to consumer (data_o is 0 when empty)
//   ready_i             : consumer accepts head entry
//   count_o             : occupancy 0..DEPTH
//   full_o, empty_o     : occupancy flags
//   overflow_o          : sticky drop flag
//   clr_ovf_i           : synchronous overflow clear (a new drop wins)
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_i,
    input  logic [DATA_WIDTH:0]       data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_WIDTH:0]       data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      overflow_o,
    input  logic                      clr_ovf_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = DATA_WIDTH + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [RW-1:0] mem [DEPTH];

    ptr_t wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    ptr_t count_q, count_d;
    logic full_q, empty_q, ovf_q;
    logic push, pop, drop;

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign pop  = !empty_q && ready_i;
    assign push = valid_i && (!full_q || pop);
    assign drop = valid_i && full_q && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr + ptr_t'(1);
        end
        if (push && !pop) begin
            count_d = count_q + ptr_t'(1);
        end else if (pop && !push) begin
            count_d = count_q - ptr_t'(1);
        end
    end

    // full comes from the pointer MSB compare, empty from the count; both
    // are registered from next-state so the outputs carry no input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_d;
            rd_ptr  <= rd_ptr_d;
            count_q <= count_d;
            full_q  <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                       (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_q <= (count_d == '0);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    assign valid_o    = !empty_q;
    assign data_o     = valid_o ? mem[rd_ptr[AW-1:0]] : '0;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer (DATA_WIDTH=8, DEPTH=4).
// A queue-based reference model tracks the expected contents and sticky
// overflow; all DUT outputs are compared on the falling edge.
module tb_alu_result_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic [8:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [8:0] data_o;
    logic [2:0] count_o;
    logic       full_o;
    logic       empty_o;
    logic       overflow_o;
    logic       clr_ovf_i;

    int checks = 0;
    int errors = 0;

    logic [8:0] q[$];
    logic       m_ovf;

    always #5 clk = ~clk;

    alu_result_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .overflow_o (overflow_o),
        .clr_ovf_i  (clr_ovf_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [8:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : 9'h000;
        chk({tag, " valid_o"},    32'(valid_o),    32'(q.size() != 0));
        chk({tag, " data_o"},     32'(data_o),     32'(exp_data));
        chk({tag, " count_o"},    32'(count_o),    32'(q.size()));
        chk({tag, " full_o"},     32'(full_o),     32'(q.size() == DEPTH));
        chk({tag, " empty_o"},    32'(empty_o),    32'(q.size() == 0));
        chk({tag, " overflow_o"}, 32'(overflow_o), 32'(m_ovf));
    endtask

    // Called on a falling edge: checks current outputs, applies inputs for
    // the next rising edge, advances the model, returns on the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [8:0] d,
                         input logic r, input logic c);
        bit do_pop, do_push, do_drop;
        check_outputs(tag);
        valid_i   = v;
        data_i    = d;
        ready_i   = r;
        clr_ovf_i = c;
        do_pop  = (q.size() != 0) && r;
        do_push = v && ((q.size() < DEPTH) || do_pop);
        do_drop = v && (q.size() == DEPTH) && !do_pop;
        @(posedge clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(d);
        if (do_drop)     m_ovf = 1'b1;
        else if (c)      m_ovf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clr_ovf_i = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single push, visible the cycle after the edge
        cycle("t1_push", 1'b1, 9'h1FF, 1'b0, 1'b0);
        cycle("t1_hold", 1'b0, 9'h000, 1'b0, 1'b0);
        cycle("t1_pop",  1'b0, 9'h000, 1'b1, 1'b0);

        // 2: fill to four, then drain in order
        for (int i = 1; i <= 4; i++) cycle("t2_fill", 1'b1, 9'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  cycle("t2_drain", 1'b0, 9'h000, 1'b1, 1'b0);
        cycle("t2_empty", 1'b0, 9'h000, 1'b0, 1'b0);

        // 3: drop while full, then clear
        for (int i = 0; i < 4; i++) cycle("t3_fill", 1'b1, 9'h010 + 9'(i), 1'b0, 1'b0);
        cycle("t3_drop",  1'b1, 9'h0AA, 1'b0, 1'b0);
        cycle("t3_clr",   1'b0, 9'h000, 1'b0, 1'b1);
        cycle("t3_after", 1'b0, 9'h000, 1'b0, 1'b0);

        // 4: push and pop together while full
        cycle("t4_pp", 1'b1, 9'h055, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("t4_drain", 1'b0, 9'h000, 1'b1, 1'b0);

        // 5: streaming push+pop, pointers wrap
        for (int i = 0; i < 10; i++) cycle("t5_stream", 1'b1, 9'(i), 1'b1, 1'b0);
        cycle("t5_tail", 1'b0, 9'h000, 1'b1, 1'b0);

        // 6: asynchronous reset with three entries and overflow set
        for (int i = 0; i < 4; i++) cycle("t6_fill", 1'b1, 9'h020 + 9'(i), 1'b0, 1'b0);
        cycle("t6_drop", 1'b1, 9'h0BB, 1'b0, 1'b0);
        cycle("t6_pop",  1'b0, 9'h000, 1'b1, 1'b0);
        check_outputs("t6_pre");
        valid_i = 1'b0; ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_outputs("t6_async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t6_idle", 1'b0, 9'h000, 1'b1, 1'b0);
        cycle("t6_push", 1'b1, 9'h123, 1'b0, 1'b0);
        cycle("t6_pop",  1'b0, 9'h000, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 99) < 60),
                  9'($urandom),
                  1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 8));
        end
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
